// File: rtl/rom_fetch_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rom_fetch_arbiter_pkg : shared types and defaults for the ROM fetch arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rom_fetch_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fsm_state_t;

  typedef enum logic [0:0] {
    RQ_M68K = 1'b0,
    RQ_Z80  = 1'b1
  } rq_id_t;

  localparam int          DEF_ADDR_W    = 24;
  localparam logic [23:0] DEF_M68K_BASE = 24'h000000;
  localparam logic [23:0] DEF_Z80_BASE  = 24'h020000;

  // Z80 sees one byte lane of the 16-bit word; odd addresses take the high lane.
  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_fetch_arbiter_if.sv
// ----------------------------------------------------------------------------
// rom_fetch_arbiter_if : CPU-side and ROM-port signals of the fetch arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rom_fetch_arbiter_if
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [23:0]       m68k_a;
  logic              m68k_rom_cs;
  logic              m68k_dtack_n;
  logic [15:0]       m68k_dout;
  logic [15:0]       z80_addr;
  logic              z80_rom_cs;
  logic              z80_wait_n;
  logic [7:0]        z80_dout;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_data;

  modport slave (
    input  m68k_a, m68k_rom_cs, z80_addr, z80_rom_cs, mem_ack, mem_data,
    output m68k_dtack_n, m68k_dout, z80_wait_n, z80_dout, mem_req, mem_addr
  );

  modport master (
    output m68k_a, m68k_rom_cs, z80_addr, z80_rom_cs, mem_ack, mem_data,
    input  m68k_dtack_n, m68k_dout, z80_wait_n, z80_dout, mem_req, mem_addr
  );

endinterface

`default_nettype wire

// File: rtl/rom_fetch_arbiter_line_buf.sv
// ----------------------------------------------------------------------------
// rom_line_buf : one-word last-fetch buffer (tag, word, valid) with compare/fill
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rom_line_buf
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BUF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [15:0]       word,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [15:0]       fill_data
);

  generate
    if (BUF_EN) begin : g_buf
      logic              r_valid;
      logic [ADDR_W-1:0] r_tag;
      logic [15:0]       r_word;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_valid <= 1'b0;
          r_tag   <= '0;
          r_word  <= '0;
        end else if (fill) begin
          r_valid <= 1'b1;
          r_tag   <= fill_addr;
          r_word  <= fill_data;
        end
      end

      assign hit  = r_valid && (r_tag == lookup_addr);
      assign word = r_word;
    end else begin : g_nobuf
      logic w_unused_buf;
      assign w_unused_buf = &{1'b0, clk, reset_n, lookup_addr, fill, fill_addr, fill_data};
      assign hit  = 1'b0;
      assign word = '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rom_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// rom_fetch_arbiter : shares one 16-bit ROM read port between 68000 and Z80
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] M68K_BASE = ADDR_W'(DEF_M68K_BASE),
  parameter logic [ADDR_W-1:0] Z80_BASE  = ADDR_W'(DEF_Z80_BASE),
  parameter bit                BUF_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  rom_fetch_arbiter_if.slave bus
);

  fsm_state_t        r_state, w_state_next;
  rq_id_t            r_owner, r_rr_last;
  logic              r_live, r_fetch_hi;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              w_mem_req, w_z_wait_n;

  logic              r_m_cs_d, r_m_pend, r_m_ready;
  logic [ADDR_W-1:0] r_m_addr;
  logic [15:0]       r_m_dout;
  logic              r_z_cs_d, r_z_pend, r_z_ready, r_z_hi;
  logic [ADDR_W-1:0] r_z_addr;
  logic [7:0]        r_z_dout;

  logic              w_m_new, w_m_want, w_m_hit, w_m_miss, w_grant_m;
  logic [ADDR_W-1:0] w_m_waddr_now, w_m_look;
  logic [15:0]       w_m_bword;
  logic              w_z_new, w_z_want, w_z_hit, w_z_miss, w_grant_z, w_z_look_hi;
  logic [ADDR_W-1:0] w_z_waddr_now, w_z_look;
  logic [15:0]       w_z_bword;
  logic              w_ack_done, w_owner_cs, w_fill_m, w_fill_z;

  logic w_unused_a;
  assign w_unused_a = &{1'b0, bus.m68k_a[23:18], bus.m68k_a[0]};

  // A request is live while cs is high and it is either new this cycle or still pending.
  assign w_m_new       = bus.m68k_rom_cs & ~r_m_cs_d;
  assign w_m_waddr_now = M68K_BASE + ADDR_W'(bus.m68k_a[17:1]);
  assign w_m_want      = bus.m68k_rom_cs & (w_m_new | r_m_pend);
  assign w_m_look      = w_m_new ? w_m_waddr_now : r_m_addr;
  assign w_m_miss      = w_m_want & ~w_m_hit;

  assign w_z_new       = bus.z80_rom_cs & ~r_z_cs_d;
  assign w_z_waddr_now = Z80_BASE + ADDR_W'(bus.z80_addr[15:1]);
  assign w_z_want      = bus.z80_rom_cs & (w_z_new | r_z_pend);
  assign w_z_look      = w_z_new ? w_z_waddr_now : r_z_addr;
  assign w_z_look_hi   = w_z_new ? bus.z80_addr[0] : r_z_hi;
  assign w_z_miss      = w_z_want & ~w_z_hit;

  assign w_ack_done = (r_state == ST_REQ) & bus.mem_ack;
  assign w_owner_cs = (r_owner == RQ_M68K) ? bus.m68k_rom_cs : bus.z80_rom_cs;
  assign w_fill_m   = w_ack_done & (r_owner == RQ_M68K);
  assign w_fill_z   = w_ack_done & (r_owner == RQ_Z80);

  rom_line_buf #(.ADDR_W(ADDR_W), .BUF_EN(BUF_EN)) u_m68k_buf (
    .clk(clk), .reset_n(reset_n), .lookup_addr(w_m_look), .hit(w_m_hit), .word(w_m_bword),
    .fill(w_fill_m), .fill_addr(r_mem_addr), .fill_data(bus.mem_data)
  );

  rom_line_buf #(.ADDR_W(ADDR_W), .BUF_EN(BUF_EN)) u_z80_buf (
    .clk(clk), .reset_n(reset_n), .lookup_addr(w_z_look), .hit(w_z_hit), .word(w_z_bword),
    .fill(w_fill_z), .fill_addr(r_mem_addr), .fill_data(bus.mem_data)
  );

  // On a tie the requester that was not served last takes the port.
  always_comb begin
    w_grant_m = 1'b0;
    w_grant_z = 1'b0;
    if (r_state == ST_IDLE) begin
      w_grant_m = w_m_miss & (~w_z_miss | (r_rr_last == RQ_Z80));
      w_grant_z = w_z_miss & (~w_m_miss | (r_rr_last == RQ_M68K));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_m | w_grant_z) w_state_next = ST_REQ;
      ST_REQ:  if (bus.mem_ack)           w_state_next = ST_IDLE;
      default:                            w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_req  = (r_state == ST_REQ);
    w_z_wait_n = ~(bus.z80_rom_cs & ~r_z_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= RQ_M68K;
      r_rr_last  <= RQ_Z80;
      r_live     <= 1'b0;
      r_fetch_hi <= 1'b0;
      r_mem_addr <= '0;
    end else if (w_grant_m | w_grant_z) begin
      r_owner    <= w_grant_m ? RQ_M68K : RQ_Z80;
      r_rr_last  <= w_grant_m ? RQ_M68K : RQ_Z80;
      r_live     <= 1'b1;
      r_fetch_hi <= w_z_look_hi;
      r_mem_addr <= w_grant_m ? w_m_look : w_z_look;
    end else begin
      // A cs drop mid-transaction still lets the fetch fill the buffer, but no handshake.
      r_live <= r_live & w_owner_cs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_cs_d <= 1'b0;
      r_m_pend <= 1'b0;
      r_m_addr <= '0;
      r_z_cs_d <= 1'b0;
      r_z_pend <= 1'b0;
      r_z_addr <= '0;
      r_z_hi   <= 1'b0;
    end else begin
      r_m_cs_d <= bus.m68k_rom_cs;
      r_m_pend <= w_m_miss & ~w_grant_m;
      if (w_m_new) r_m_addr <= w_m_waddr_now;
      r_z_cs_d <= bus.z80_rom_cs;
      r_z_pend <= w_z_miss & ~w_grant_z;
      if (w_z_new) begin
        r_z_addr <= w_z_waddr_now;
        r_z_hi   <= bus.z80_addr[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_ready <= 1'b0;
      r_m_dout  <= '0;
      r_z_ready <= 1'b0;
      r_z_dout  <= '0;
    end else begin
      if (!bus.m68k_rom_cs) begin
        r_m_ready <= 1'b0;
      end else if (w_m_want & w_m_hit) begin
        r_m_ready <= 1'b1;
        r_m_dout  <= w_m_bword;
      end else if (w_fill_m & r_live) begin
        r_m_ready <= 1'b1;
        r_m_dout  <= bus.mem_data;
      end

      if (!bus.z80_rom_cs) begin
        r_z_ready <= 1'b0;
      end else if (w_z_want & w_z_hit) begin
        r_z_ready <= 1'b1;
        r_z_dout  <= pick_byte(w_z_bword, w_z_look_hi);
      end else if (w_fill_z & r_live) begin
        r_z_ready <= 1'b1;
        r_z_dout  <= pick_byte(bus.mem_data, r_fetch_hi);
      end
    end
  end

  assign bus.mem_req      = w_mem_req;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.m68k_dtack_n = ~r_m_ready;
  assign bus.m68k_dout    = r_m_dout;
  assign bus.z80_wait_n   = w_z_wait_n;
  assign bus.z80_dout     = r_z_dout;

endmodule

`default_nettype wire

// File: tb/tb_rom_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rom_fetch_arbiter : scoreboard bench for rom_fetch_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rom_fetch_arbiter;
  import rom_fetch_arbiter_pkg::*;

  localparam int          AW     = 24;
  localparam logic [23:0] M_BASE = 24'h000000;
  localparam logic [23:0] Z_BASE = 24'h020000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  rom_fetch_arbiter_if #(.ADDR_W(AW)) bus ();

  rom_fetch_arbiter #(.ADDR_W(AW), .M68K_BASE(M_BASE), .Z80_BASE(Z_BASE), .BUF_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, req_count = 0, ack_cyc = 0, lat_cfg = 3;
  int m_done_cnt = 0, m_done_cyc = 0, z_done_cnt = 0, z_done_cyc = 0;
  bit m_seen = 1'b0, z_seen = 1'b0;

  logic [23:0] exp_mem_q[$];
  logic [15:0] exp_m_q[$];
  logic [7:0]  exp_z_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rom_word(input logic [23:0] wa);
    case (wa)
      24'h000080: return 16'h4E71;
      24'h020091: return 16'hABCD;
      default:    return wa[15:0] ^ 16'hC3A5 ^ {wa[23:16], 8'h00};
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ROM port model: acks lat_cfg cycles after mem_req rises, checks each request address.
  initial begin
    bit          busy;
    int          lat;
    logic [23:0] a0;
    busy = 1'b0; lat = 0; a0 = '0;
    bus.mem_ack = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (busy) begin
        lat++;
        if (lat >= lat_cfg) begin
          if (bus.mem_req) check("mem_addr_stable", 32'(bus.mem_addr), 32'(a0));
          bus.mem_data = rom_word(a0);
          bus.mem_ack  = 1'b1;
          ack_cyc      = cyc;
          busy         = 1'b0;
        end
      end else if (bus.mem_req) begin
        busy = 1'b1;
        lat  = 0;
        a0   = bus.mem_addr;
        req_count++;
        if (exp_mem_q.size() == 0) check("mem_unexpected_req", exp_mem_q.size(), 1);
        else                       check("mem_addr", 32'(bus.mem_addr), 32'(exp_mem_q.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.m68k_rom_cs && !bus.m68k_dtack_n && !m_seen) begin
      m_seen = 1'b1;
      m_done_cnt++;
      m_done_cyc = cyc;
      if (exp_m_q.size() == 0) check("m68k_unexpected_dtack", exp_m_q.size(), 1);
      else                     check("m68k_dout", 32'(bus.m68k_dout), 32'(exp_m_q.pop_front()));
    end
    if (!bus.m68k_rom_cs) m_seen = 1'b0;
    if (bus.z80_rom_cs && bus.z80_wait_n && !z_seen) begin
      z_seen = 1'b1;
      z_done_cnt++;
      z_done_cyc = cyc;
      if (exp_z_q.size() == 0) check("z80_unexpected_ready", exp_z_q.size(), 1);
      else                     check("z80_dout", 32'(bus.z80_dout), 32'(exp_z_q.pop_front()));
    end
    if (!bus.z80_rom_cs) z_seen = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m68k_read(input logic [23:0] a, input bit hit);
    logic [23:0] wa;
    int r0, d0, t0;
    wa = M_BASE + {7'd0, a[17:1]};
    r0 = req_count; d0 = m_done_cnt;
    exp_m_q.push_back(rom_word(wa));
    if (!hit) exp_mem_q.push_back(wa);
    bus.m68k_a = a;
    bus.m68k_rom_cs = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40 && m_done_cnt == d0; i++) @(posedge clk);
    #1;
    check("m68k_done", m_done_cnt - d0, 1);
    if (hit) check("m68k_hit_latency", m_done_cyc - t0, 1);
    else     check("m68k_dtack_after_ack", m_done_cyc - ack_cyc, 1);
    check("m68k_port_reqs", req_count - r0, hit ? 0 : 1);
    bus.m68k_rom_cs = 1'b0;
    @(negedge clk);
    check("m68k_dtack_held", 32'(bus.m68k_dtack_n), 32'(1'b0));
    @(negedge clk);
    check("m68k_dtack_release", 32'(bus.m68k_dtack_n), 32'(1'b1));
    tick(1);
  endtask

  task automatic z80_read(input logic [15:0] a, input bit hit);
    logic [23:0] wa;
    logic [15:0] w;
    int r0, d0, t0;
    wa = Z_BASE + {9'd0, a[15:1]};
    w  = rom_word(wa);
    r0 = req_count; d0 = z_done_cnt;
    exp_z_q.push_back(a[0] ? w[15:8] : w[7:0]);
    if (!hit) exp_mem_q.push_back(wa);
    bus.z80_addr = a;
    bus.z80_rom_cs = 1'b1;
    t0 = cyc;
    #1;
    check("z80_wait_same_cycle", 32'(bus.z80_wait_n), 32'(1'b0));
    for (int i = 0; i < 40 && z_done_cnt == d0; i++) @(posedge clk);
    #1;
    check("z80_done", z_done_cnt - d0, 1);
    if (hit) check("z80_hit_latency", z_done_cyc - t0, 1);
    else     check("z80_wait_after_ack", z_done_cyc - ack_cyc, 1);
    check("z80_port_reqs", req_count - r0, hit ? 0 : 1);
    bus.z80_rom_cs = 1'b0;
    tick(2);
  endtask

  // Both selects rise together and both miss: the 68000 must reach the port first.
  task automatic dual_read(input logic [23:0] ma, input logic [15:0] za);
    logic [23:0] mwa, zwa;
    logic [15:0] zw;
    int dm, dz;
    mwa = M_BASE + {7'd0, ma[17:1]};
    zwa = Z_BASE + {9'd0, za[15:1]};
    zw  = rom_word(zwa);
    dm = m_done_cnt; dz = z_done_cnt;
    exp_mem_q.push_back(mwa);
    exp_mem_q.push_back(zwa);
    exp_m_q.push_back(rom_word(mwa));
    exp_z_q.push_back(za[0] ? zw[15:8] : zw[7:0]);
    bus.m68k_a = ma; bus.z80_addr = za;
    bus.m68k_rom_cs = 1'b1; bus.z80_rom_cs = 1'b1;
    for (int i = 0; i < 60 && (m_done_cnt == dm || z_done_cnt == dz); i++) @(posedge clk);
    #1;
    check("dual_m68k_done", m_done_cnt - dm, 1);
    check("dual_z80_done", z_done_cnt - dz, 1);
    check("dual_m68k_first", m_done_cyc < z_done_cyc ? 1 : 0, 1);
    bus.m68k_rom_cs = 1'b0; bus.z80_rom_cs = 1'b0;
    tick(2);
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    bus.m68k_rom_cs = 1'b0;
    bus.z80_rom_cs = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int r0, lows;
    bus.m68k_a = '0; bus.m68k_rom_cs = 1'b0;
    bus.z80_addr = '0; bus.z80_rom_cs = 1'b0;
    reset_n = 1'b0;
    tick(2);
    check("rst_dtack_n", 32'(bus.m68k_dtack_n), 32'(1'b1));
    check("rst_wait_n", 32'(bus.z80_wait_n), 32'(1'b1));
    check("rst_mem_req", 32'(bus.mem_req), 32'(1'b0));
    check("rst_mem_addr", 32'(bus.mem_addr), 32'(24'h0));
    check("rst_m68k_dout", 32'(bus.m68k_dout), 32'(16'h0));
    check("rst_z80_dout", 32'(bus.z80_dout), 32'(8'h0));
    reset_n = 1'b1;
    tick(2);

    m68k_read(24'h000100, 1'b0);
    m68k_read(24'h000100, 1'b1);
    z80_read(16'h0123, 1'b0);
    z80_read(16'h0122, 1'b1);
    m68k_read(24'h03FFFE, 1'b0);
    m68k_read(24'h000102, 1'b0);
    z80_read(16'hEFFF, 1'b0);

    apply_reset();
    dual_read(24'h000200, 16'h0400);
    dual_read(24'h000204, 16'h0402);

    // Reset while a fetch is outstanding; the late ack must be ignored.
    lat_cfg = 6;
    r0 = req_count;
    exp_mem_q.push_back(24'h000400);
    bus.m68k_a = 24'h000800;
    bus.m68k_rom_cs = 1'b1;
    for (int i = 0; i < 20 && req_count == r0; i++) @(posedge clk);
    #1;
    check("rst_req_seen", req_count - r0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'(1'b0));
    check("rst_mid_dtack_n", 32'(bus.m68k_dtack_n), 32'(1'b1));
    bus.m68k_rom_cs = 1'b0;
    tick(1);
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.m68k_dtack_n) lows++;
    end
    check("rst_late_ack_no_dtack", lows, 0);
    tick(1);
    lat_cfg = 3;
    m68k_read(24'h000800, 1'b0);

    // cs dropped while in REQ: no dtack, but the buffer still fills.
    r0 = req_count;
    exp_mem_q.push_back(24'h000500);
    bus.m68k_a = 24'h000A00;
    bus.m68k_rom_cs = 1'b1;
    for (int i = 0; i < 20 && req_count == r0; i++) @(posedge clk);
    #1;
    check("drop_req_seen", req_count - r0, 1);
    bus.m68k_rom_cs = 1'b0;
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!bus.m68k_dtack_n) lows++;
    end
    check("drop_no_dtack", lows, 0);
    tick(1);
    m68k_read(24'h000A00, 1'b1);

    check("mem_q_left", exp_mem_q.size(), 0);
    check("m68k_q_left", exp_m_q.size(), 0);
    check("z80_q_left", exp_z_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
